// File: rtl/his_sched_pkg.sv
// ---------------------------------------------------------------------------
// his_sched_pkg
//   Shared types and default constants for the histogram acquisition
//   scheduler.
//   - sched_state_t : scheduler FSM states
//   - *_DEF         : default widths, counts and gap lengths
//   - miss_code()   : all-ones word written for a timed-out slot
// ---------------------------------------------------------------------------
package his_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam int NP_DEF          = 10;
    localparam int PIXEL_NUM_DEF   = 3;
    localparam int ACQ_NUM_DEF     = 2;
    localparam int GAP_CYC_DEF     = 4;
    localparam int TIMEOUT_CYC_DEF = 16;

    // All ones at the given word width (2^np - 1); valid for np <= 31.
    function automatic logic [31:0] miss_code(input int np);
        miss_code = (32'd1 << np) - 32'd1;
    endfunction

endpackage

// File: rtl/his_slot_counter.sv
// ---------------------------------------------------------------------------
// his_slot_counter
//   Nested slot counter walking word (w, fastest), pixel (p), acquisition (a).
//   Ports:
//     clk        in  clock, rising edge
//     res        in  async active-low reset
//     clear      in  synchronous return to slot (a0,p0,w0)
//     advance    in  step to the next slot (wraps after the last slot)
//     sel        out currently selected pixel index
//     last_slot  out high while at a=ACQ_NUM-1, p=PIXEL_NUM-1, w=1
// ---------------------------------------------------------------------------
module his_slot_counter
    import his_sched_pkg::*;
#(
    parameter int PIXEL_NUM = PIXEL_NUM_DEF,
    parameter int ACQ_NUM   = ACQ_NUM_DEF,
    parameter int PW        = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1,
    parameter int AW        = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1
) (
    input  logic          clk,
    input  logic          res,
    input  logic          clear,
    input  logic          advance,
    output logic [PW-1:0] sel,
    output logic          last_slot
);

    localparam logic [PW-1:0] P_LAST = PW'(PIXEL_NUM - 1);
    localparam logic [AW-1:0] A_LAST = AW'(ACQ_NUM - 1);

    logic          w_q, w_d;
    logic [PW-1:0] p_q, p_d;
    logic [AW-1:0] a_q, a_d;

    always_comb begin
        w_d = w_q;
        p_d = p_q;
        a_d = a_q;
        if (clear) begin
            w_d = 1'b0;
            p_d = '0;
            a_d = '0;
        end else if (advance) begin
            if (!w_q) begin
                w_d = 1'b1;
            end else begin
                w_d = 1'b0;
                if (p_q == P_LAST) begin
                    p_d = '0;
                    a_d = (a_q == A_LAST) ? '0 : a_q + AW'(1);
                end else begin
                    p_d = p_q + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            w_q <= 1'b0;
            p_q <= '0;
            a_q <= '0;
        end else begin
            w_q <= w_d;
            p_q <= p_d;
            a_q <= a_d;
        end
    end

    assign sel       = p_q;
    assign last_slot = w_q && (p_q == P_LAST) && (a_q == A_LAST);

endmodule

// File: rtl/his_acq_scheduler.sv
// ---------------------------------------------------------------------------
// his_acq_scheduler
//   Sequences per-pixel TDC word streams into one shared histogram-builder
//   write port in the fixed order acq -> pixel -> word (2 words per acq),
//   then idles the port for GAP_CYC cycles, pulses his_done and either stops
//   or restarts (cont_mode / pending start).
//   Optional feature macro: HIS_SCHED_TIMEOUT_EN. When defined, a selected
//   pixel that stays invalid for TIMEOUT_CYC cycles gets an all-ones miss
//   word written in its place and miss_cnt counts these. When undefined the
//   stall is unbounded and miss_cnt is tied to 0.
//   Ports:
//     clk        in  clock, rising edge
//     res        in  async active-low reset
//     start      in  begin one histogram (pulse)
//     cont_mode  in  auto-restart after each histogram
//     req_valid  in  per-pixel word valid
//     req_data   in  per-pixel word, pixel p at [p*NP +: NP]
//     req_ready  out one-hot accept to the selected pixel
//     his_wr_en  out builder write enable (one cycle after accept)
//     his_data   out builder data
//     busy       out FILL or FLUSH active
//     his_done   out one-cycle completion pulse
//     his_cnt    out completed histograms (wraps)
//     miss_cnt   out inserted miss words (wraps)
// ---------------------------------------------------------------------------
module his_acq_scheduler
    import his_sched_pkg::*;
#(
    parameter int NP        = NP_DEF,
    parameter int PIXEL_NUM = PIXEL_NUM_DEF,
    parameter int ACQ_NUM   = ACQ_NUM_DEF,
    parameter int GAP_CYC   = GAP_CYC_DEF
`ifdef HIS_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    start,
    input  logic                    cont_mode,
    input  logic [PIXEL_NUM-1:0]    req_valid,
    input  logic [PIXEL_NUM*NP-1:0] req_data,
    output logic [PIXEL_NUM-1:0]    req_ready,
    output logic                    his_wr_en,
    output logic [NP-1:0]           his_data,
    output logic                    busy,
    output logic                    his_done,
    output logic [15:0]             his_cnt,
    output logic [15:0]             miss_cnt
);

    localparam int PW = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    sched_state_t  state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          start_pend_q, start_pend_d;
    logic          his_wr_en_q, his_wr_en_d;
    logic [NP-1:0] his_data_q, his_data_d;
    logic          his_done_q, his_done_d;
    logic [15:0]   his_cnt_q, his_cnt_d;

    logic [PW-1:0] sel;
    logic          last_slot;
    logic          slot_clear;
    logic          sel_valid;
    logic [NP-1:0] sel_data;
    logic          transfer;
    logic          timeout_hit;
    logic          advance;

    his_slot_counter #(
        .PIXEL_NUM (PIXEL_NUM),
        .ACQ_NUM   (ACQ_NUM),
        .PW        (PW)
    ) u_slot (
        .clk       (clk),
        .res       (res),
        .clear     (slot_clear),
        .advance   (advance),
        .sel       (sel),
        .last_slot (last_slot)
    );

    // Grant depends only on registered state and slot, never on req_valid,
    // so a pixel can safely derive its valid from its own ready.
    always_comb begin
        req_ready = '0;
        if (state_q == FILL) begin
            req_ready[sel] = 1'b1;
        end
    end

    always_comb begin
        sel_valid = req_valid[sel];
        sel_data  = req_data[int'(sel)*NP +: NP];
    end

    assign transfer = (state_q == FILL) && sel_valid;

`ifdef HIS_SCHED_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [31:0]   MISS_WIDE = miss_code(NP);
    localparam logic [NP-1:0] MISS_WORD = MISS_WIDE[NP-1:0];

    logic [SW-1:0] stall_q, stall_d;
    logic [15:0]   miss_cnt_q, miss_cnt_d;

    // The stall that reaches TIMEOUT_CYC is itself the cycle that inserts
    // the miss word, so the slot moves on after exactly TIMEOUT_CYC stalls.
    assign timeout_hit = (state_q == FILL) && !sel_valid &&
                         (stall_q == SW'(TIMEOUT_CYC - 1));

    always_comb begin
        stall_d    = stall_q;
        miss_cnt_d = miss_cnt_q;
        if ((state_q != FILL) || transfer || timeout_hit) begin
            stall_d = '0;
        end else begin
            stall_d = stall_q + SW'(1);
        end
        if (timeout_hit) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            stall_q    <= '0;
            miss_cnt_q <= '0;
        end else begin
            stall_q    <= stall_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign miss_cnt = miss_cnt_q;
`else
    assign timeout_hit = 1'b0;
    assign miss_cnt    = '0;
`endif

    assign advance = transfer || timeout_hit;

    // Next state plus output-register inputs. Accepted words appear on the
    // builder port one cycle later; on idle cycles his_data keeps its value.
    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        start_pend_d = start_pend_q;
        his_done_d   = 1'b0;
        his_cnt_d    = his_cnt_q;
        slot_clear   = 1'b0;
        his_wr_en_d  = advance;
        his_data_d   = his_data_q;

        if (transfer) begin
            his_data_d = sel_data;
        end
`ifdef HIS_SCHED_TIMEOUT_EN
        else if (timeout_hit) begin
            his_data_d = MISS_WORD;
        end
`endif

        case (state_q)
            IDLE: begin
                slot_clear = 1'b1;
                gap_d      = '0;
                if (start) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (start) begin
                    start_pend_d = 1'b1;
                end
                if (advance && last_slot) begin
                    state_d = FLUSH;
                    gap_d   = '0;
                end
            end
            FLUSH: begin
                if (start) begin
                    start_pend_d = 1'b1;
                end
                // his_done and his_cnt are registered so they become
                // visible in the DONE cycle itself.
                if (gap_q == GAP_LAST) begin
                    state_d    = DONE;
                    his_done_d = 1'b1;
                    his_cnt_d  = his_cnt_q + 16'd1;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            DONE: begin
                slot_clear   = 1'b1;
                gap_d        = '0;
                start_pend_d = 1'b0;
                if (cont_mode || start_pend_q || start) begin
                    state_d = FILL;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q      <= IDLE;
            gap_q        <= '0;
            start_pend_q <= 1'b0;
            his_wr_en_q  <= 1'b0;
            his_data_q   <= '0;
            his_done_q   <= 1'b0;
            his_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            start_pend_q <= start_pend_d;
            his_wr_en_q  <= his_wr_en_d;
            his_data_q   <= his_data_d;
            his_done_q   <= his_done_d;
            his_cnt_q    <= his_cnt_d;
        end
    end

    assign his_wr_en = his_wr_en_q;
    assign his_data  = his_data_q;
    assign his_done  = his_done_q;
    assign his_cnt   = his_cnt_q;
    assign busy      = (state_q == FILL) || (state_q == FLUSH);

endmodule

// File: tb/tb_his_acq_scheduler.sv
// ---------------------------------------------------------------------------
// tb_his_acq_scheduler
//   Self-checking bench for his_acq_scheduler (PIXEL_NUM=3, ACQ_NUM=2,
//   GAP_CYC=4). A pixel model pushes each word it hands over into an expected
//   queue; a monitor pops and compares whenever the builder port writes, and
//   checks count, gap and busy at every his_done pulse.
//   Covers the HIS_SCHED_TIMEOUT_EN build and the default build.
// ---------------------------------------------------------------------------
module tb_his_acq_scheduler;
    import his_sched_pkg::*;

    localparam int NP    = 10;
    localparam int PN    = 3;
    localparam int AN    = 2;
    localparam int GAP   = 4;
    localparam int TO    = 16;
    localparam int WORDS = 2 * PN * AN;

    logic             clk       = 1'b0;
    logic             res       = 1'b1;
    logic             start     = 1'b0;
    logic             cont_mode = 1'b0;
    logic [PN-1:0]    req_valid = '0;
    logic [PN*NP-1:0] req_data  = '0;
    logic [PN-1:0]    req_ready;
    logic             his_wr_en;
    logic [NP-1:0]    his_data;
    logic             busy;
    logic             his_done;
    logic [15:0]      his_cnt;
    logic [15:0]      miss_cnt;

    logic [NP-1:0] exp_q[$];
    logic [PN-1:0] mask        = '0;
    int            k[PN];
    int            checks      = 0;
    int            failures    = 0;
    int            cyc         = 0;
    int            last_wr_cyc = 0;
    int            hist_writes = 0;
    int            done_seen   = 0;
    int            exp_his     = 0;
    int            stall_model = 0;
    int            exp_miss    = 0;

    always #5 clk = ~clk;

    his_acq_scheduler dut (
        .clk       (clk),
        .res       (res),
        .start     (start),
        .cont_mode (cont_mode),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .his_wr_en (his_wr_en),
        .his_data  (his_data),
        .busy      (busy),
        .his_done  (his_done),
        .his_cnt   (his_cnt),
        .miss_cnt  (miss_cnt)
    );

    // Word k of pixel p; always below 1000 so it never equals the miss code.
    function automatic logic [NP-1:0] word_of(input int p, input int kk);
        return NP'((108 + 131 * p + 97 * kk) % 1000);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Pixel model: drives valid/data mid-cycle and records every word that
    // the upcoming rising edge will accept.
    always @(negedge clk) begin
        req_valid = mask;
        for (int p = 0; p < PN; p++) begin
            req_data[p*NP +: NP] = word_of(p, k[p]);
        end
        if (res) begin
            for (int p = 0; p < PN; p++) begin
                if (req_valid[p] && req_ready[p]) begin
                    exp_q.push_back(word_of(p, k[p]));
                    k[p]++;
                end
            end
`ifdef HIS_SCHED_TIMEOUT_EN
            if ((req_ready != '0) && ((req_ready & req_valid) == '0)) begin
                stall_model++;
                if (stall_model == TO) begin
                    exp_q.push_back(NP'((1 << NP) - 1));
                    exp_miss++;
                    stall_model = 0;
                end
            end else begin
                stall_model = 0;
            end
`endif
        end
    end

    // Monitor: compares every builder write and every completion pulse.
    always @(negedge clk) begin
        if (res) begin
            check_output("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
            if (his_wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_write: got data %0d expected no write (t=%0t)",
                             his_data, $time);
                end else begin
                    check_output("wr_data", 32'(his_data), 32'(exp_q.pop_front()));
                end
                hist_writes++;
                last_wr_cyc = cyc;
            end
            if (his_done) begin
                exp_his++;
                check_output("done_his_cnt", 32'(his_cnt), 32'(exp_his));
                check_output("done_busy", 32'(busy), 32'd0);
                check_output("done_words", 32'(hist_writes), 32'(WORDS));
                check_output("done_gap", 32'(cyc - last_wr_cyc), 32'(GAP));
                hist_writes = 0;
                done_seen++;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_seen < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("wait_done_timeout", 32'(done_seen >= target), 32'd1);
    endtask

    task automatic wait_writes(input int target, input int budget);
        int n = 0;
        while (hist_writes < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("wait_writes_timeout", 32'(hist_writes >= target), 32'd1);
    endtask

    task automatic apply_stimulus_reset();
        res = 1'b0;
        #1;
        exp_q.delete();
        for (int p = 0; p < PN; p++) k[p] = 0;
        hist_writes = 0;
        exp_his     = 0;
        done_seen   = 0;
        stall_model = 0;
        check_output("rst_wr_en", 32'(his_wr_en), 32'd0);
        check_output("rst_data", 32'(his_data), 32'd0);
        check_output("rst_ready", 32'(req_ready), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(his_done), 32'd0);
        check_output("rst_his_cnt", 32'(his_cnt), 32'd0);
        check_output("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #2 res = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish before timeout");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int p = 0; p < PN; p++) k[p] = 0;
        #2;
        apply_stimulus_reset();
        mask = 3'b111;

        // 1: all pixels valid, single histogram.
        $display("[TB] test 1: single histogram");
        pulse_start();
        check_output("t1_first_ready", 32'(req_ready), 32'd1);
        check_output("t1_busy", 32'(busy), 32'd1);
        wait_done(1, 100);
        check_output("t1_idle_busy", 32'(busy), 32'd0);
        check_output("t1_his_cnt", 32'(his_cnt), 32'd1);

        // 2: pixel 1 withholds its first word for five cycles.
        $display("[TB] test 2: pixel 1 stall");
        mask = 3'b101;
        pulse_start();
        begin
            int n = 0;
            while (!req_ready[1] && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            check_output("t2_ready_hold", 32'(req_ready), 32'd2);
            @(posedge clk);
            #1;
            check_output("t2_wr_idle", 32'(his_wr_en), 32'd0);
        end
        mask = 3'b111;
        wait_done(2, 100);

        // 3: continuous mode, then cleared mid-histogram.
        $display("[TB] test 3: continuous mode");
        cont_mode = 1'b1;
        pulse_start();
        wait_done(5, 200);
        wait_writes(3, 50);
        cont_mode = 1'b0;
        wait_done(6, 100);
        repeat (10) @(posedge clk);
        #1;
        check_output("t3_stopped_busy", 32'(busy), 32'd0);
        check_output("t3_stopped_writes", 32'(hist_writes), 32'd0);
        check_output("t3_his_cnt", 32'(his_cnt), 32'd6);

        // 4: start arriving during the flush gap runs one more histogram.
        $display("[TB] test 4: start during flush");
        pulse_start();
        wait_writes(WORDS, 100);
        pulse_start();
        wait_done(8, 200);
        repeat (10) @(posedge clk);
        #1;
        check_output("t4_busy", 32'(busy), 32'd0);
        check_output("t4_his_cnt", 32'(his_cnt), 32'd8);

        // 5: asynchronous reset in the middle of a histogram.
        $display("[TB] test 5: reset mid-histogram");
        pulse_start();
        wait_writes(7, 50);
        #1;
        apply_stimulus_reset();
        pulse_start();
        check_output("t5_restart_ready", 32'(req_ready), 32'd1);
        check_output("t5_his_cnt", 32'(his_cnt), 32'd0);
        wait_done(1, 100);

        // 6: pixel 2 never valid.
        $display("[TB] test 6: pixel 2 silent");
        mask = 3'b011;
        pulse_start();
`ifdef HIS_SCHED_TIMEOUT_EN
        wait_done(2, 400);
        check_output("t6_miss_model", 32'(miss_cnt), 32'(exp_miss));
        check_output("t6_miss_cnt", 32'(miss_cnt), 32'd4);
`else
        repeat (60) @(posedge clk);
        #1;
        check_output("t6_stall_writes", 32'(hist_writes), 32'd4);
        check_output("t6_stall_busy", 32'(busy), 32'd1);
        check_output("t6_stall_wr", 32'(his_wr_en), 32'd0);
        check_output("t6_miss_cnt", 32'(miss_cnt), 32'd0);
        mask = 3'b111;
        wait_done(2, 100);
`endif
        mask = 3'b111;

        repeat (5) @(posedge clk);
        #1;
        check_output("end_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
